serial_adder: RTL and testbench

- Parametrised bit-serial adder/subtractor, the sequential successor to our single-bit half-adder cell.
- Accepts two WIDTH-bit operands through a valid/ready handshake and processes one bit per clock, LSB first, through a single full-adder bit cell.
- Presents sum, carry-out and signed overflow through an output valid/ready handshake.
- Used wherever area matters more than throughput, e.g. low-rate accumulation and checksum paths.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_fa_bit.sv | 33 +++
 rtl/serial_adder.sv | 156 +++++++++++++++
 tb/tb_serial_adder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared types and helpers for the bit-serial adder/subtractor.
//   state_t    : control FSM state encoding (IDLE, RUN, DONE), 2 bits.
//   cnt_width  : width of the bit counter that indexes operand bits.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The bit counter only has to reach WIDTH-1. The result is clamped to 1 so
    // that a counter is never zero bits wide.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// ---------------------------------------------------------------------------
// fa_bit
//
// Combinational one-bit full adder, built from two half-adder stages plus an
// OR. This is the single arithmetic cell that the serial adder reuses once per
// clock.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// ---------------------------------------------------------------------------
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    // First half adder combines the operand bits. The second half adder folds
    // in the carry. The two stages can never both produce a carry, so a plain
    // OR merges them.
    assign ha1_s = a ^ b;
    assign ha1_c = a & b;
    assign s     = ha1_s ^ ci;
    assign ha2_c = ha1_s & ci;
    assign co    = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. Operands are accepted through a valid/ready
// handshake and processed LSB first, one bit per clock, through a single
// full-adder cell. The result is presented through a second valid/ready
// handshake.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : a, b, cin, sub are valid
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : WIDTH-bit operands
//   cin       : carry-in (add mode only)
//   sub       : 0 = a+b+cin, 1 = a-b
//   out_valid : sum, cout, ovf are valid
//   out_ready : downstream accepts the result
//   sum       : WIDTH-bit result (modulo 2^WIDTH)
//   cout      : carry out of the MSB (sub mode: 1 = no borrow)
//   ovf       : signed overflow
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             carry_msb;
    logic             cout_r;
    logic             ovf_r;
    logic             bit_s;
    logic             bit_co;

    // The single arithmetic cell. The counter selects which operand bit it
    // sees this cycle.
    fa_bit u_fa_bit (
        .a  (opa[cnt]),
        .b  (opb[cnt]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Only IDLE accepts operands, so a
    // result leaves DONE before the next operation can start.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Subtraction is computed as a + ~b + 1: b is inverted when it is
    // latched, and the carry is preset to 1. Each sum bit enters from the MSB
    // side, so after WIDTH shifts bit 0 sits at position 0. The carry out of
    // bit WIDTH-2 is the carry into the MSB. It is kept so that the signed
    // overflow can be formed on the final edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            sum_r     <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            cout_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b ^ {WIDTH{sub}};
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_r <= {bit_s, sum_r[WIDTH-1:1]};
                    carry <= bit_co;
                    if (cnt == CNT_PENULT) begin
                        carry_msb <= bit_co;
                    end
                    if (cnt == CNT_LAST) begin
                        cout_r <= bit_co;
                        ovf_r  <= carry_msb ^ bit_co;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder at WIDTH=8. Expected results come from a
// behavioural model of the arithmetic. They are pushed to a scoreboard when
// operands are accepted and popped when the DUT raises out_valid.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH   = 8;
    localparam int MAX_LAT = 20;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } result_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    result_t sb[$];
    result_t lastExp;
    int      checks;
    int      errors;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 unit after the next rising edge. Outputs are sampled and
    // inputs are driven at that point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model. The operation is a + b' + c, where b' is b or ~b and
    // c is cin or 1. Signed overflow occurs when the two addends share a sign
    // that differs from the sign of the result.
    function automatic result_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                      input logic tcin, input logic tsub);
        result_t          r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        bb     = tsub ? ~tb : tb;
        full   = {1'b0, ta} + {1'b0, bb} + {{WIDTH{1'b0}}, (tsub ? 1'b1 : tcin)};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (ta[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != ta[WIDTH-1]);
        return r;
    endfunction

    // Present one operation and let the DUT accept it. The caller must be in
    // IDLE. When keep is 0, the operation is about to be discarded by reset,
    // so nothing is queued for it.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tcin, input logic tsub, input bit keep);
        checkVal("in_ready_before_accept", 32'(in_ready), 32'(1'b1));
        if (keep) begin
            sb.push_back(model(ta, tb, tcin, tsub));
        end
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        tick();
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    // Wait for out_valid within a bounded budget. Check the latency, then pop
    // the scoreboard and compare the result fields.
    task automatic checkOutput(input string tag);
        int      lat;
        result_t e;
        lat = 0;
        while (out_valid !== 1'b1 && lat < MAX_LAT) begin
            tick();
            lat++;
        end
        checkVal({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        if (sb.size() == 0) begin
            checkVal({tag, "_scoreboard_nonempty"}, 32'(0), 32'(1));
            return;
        end
        e       = sb.pop_front();
        lastExp = e;
        checkVal({tag, "_sum"}, 32'(sum), 32'(e.sum));
        checkVal({tag, "_cout"}, 32'(cout), 32'(e.cout));
        checkVal({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        checkVal({tag, "_in_ready_done"}, 32'(in_ready), 32'(1'b0));
    endtask

    // Accept the pending result and confirm the return to IDLE.
    task automatic releaseOutput(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkVal({tag, "_idle_in_ready"}, 32'(in_ready), 32'(1'b1));
        checkVal({tag, "_idle_out_valid"}, 32'(out_valid), 32'(1'b0));
    endtask

    // Directed sequence: reset, arithmetic cases, backpressure, reset in RUN.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkVal("rst_in_ready", 32'(in_ready), 32'(1'b1));
        checkVal("rst_out_valid", 32'(out_valid), 32'(1'b0));
        checkVal("rst_sum", 32'(sum), 32'(0));
        checkVal("rst_cout", 32'(cout), 32'(1'b0));
        checkVal("rst_ovf", 32'(ovf), 32'(1'b0));

        $display("[TB] add with carry ripple");
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
        checkOutput("ripple");
        releaseOutput("ripple");

        $display("[TB] signed overflow");
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_add");
        releaseOutput("ovf_add");

        $display("[TB] carry out with cin");
        applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("cin_cout");
        releaseOutput("cin_cout");

        $display("[TB] subtract with borrow, cin ignored");
        applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
        checkOutput("sub_borrow");
        releaseOutput("sub_borrow");

        $display("[TB] subtract with signed overflow");
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
        checkOutput("sub_ovf");
        releaseOutput("sub_ovf");

        $display("[TB] alternating bits with cin");
        applyStimulus(8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
        checkOutput("alt_bits");

        $display("[TB] backpressure in DONE");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            tick();
            checkVal("bp_out_valid", 32'(out_valid), 32'(1'b1));
            checkVal("bp_in_ready", 32'(in_ready), 32'(1'b0));
            checkVal("bp_sum", 32'(sum), 32'(lastExp.sum));
            checkVal("bp_cout", 32'(cout), 32'(lastExp.cout));
            checkVal("bp_ovf", 32'(ovf), 32'(lastExp.ovf));
        end
        in_valid = 1'b0;
        releaseOutput("bp");
        checkVal("bp_sum_after_release", 32'(sum), 32'(lastExp.sum));
        tick();
        checkVal("bp_no_phantom_accept", 32'(in_ready), 32'(1'b1));

        $display("[TB] reset during RUN");
        applyStimulus(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkVal("rstrun_in_ready", 32'(in_ready), 32'(1'b1));
        checkVal("rstrun_out_valid", 32'(out_valid), 32'(1'b0));
        checkVal("rstrun_sum", 32'(sum), 32'(0));
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            checkVal("rstrun_no_output", 32'(out_valid), 32'(1'b0));
        end
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        checkOutput("post_rst");
        releaseOutput("post_rst");

        checkVal("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
